// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
// Holds the FSM state encoding, the owner encoding and a helper that turns
// the memory latency parameter into the BUSY counter load value.
package mem_arbiter_pkg;

    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    // BUSY lasts mem_lat cycles: load mem_lat-1 and finish when the count is 0.
    function automatic logic [CNT_W-1:0] lat_load(input int mem_lat);
        return CNT_W'(mem_lat - 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant, purely combinational.
// Ports:
//   i_req_if  instruction-fetch request
//   i_req_d   data-port request
//   i_last    owner granted most recently
//   o_grant   one-hot grant, bit 0 = instruction port, bit 1 = data port
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic       i_req_if,
    input  logic       i_req_d,
    input  owner_t     i_last,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        if (i_req_if && i_req_d) begin
            // Tie: favour the port that was not served last.
            if (i_last == OWN_IF) begin
                o_grant = 2'b10;
            end else begin
                o_grant = 2'b01;
            end
        end else if (i_req_if) begin
            o_grant = 2'b01;
        end else if (i_req_d) begin
            o_grant = 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between an instruction-fetch port
// (read only) and a data port (read/write).
// Handshake: a requester raises req with its address (and we/wdata) and holds
// them until its ack; ack is a one-cycle pulse and rdata is valid only while
// ack is high. Requests are sampled in IDLE only; the access in flight uses
// the copies latched on the grant edge.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   if_req/if_addr           fetch request and byte address
//   if_ack/if_rdata          fetch completion pulse and data
//   d_req/d_we/d_addr/d_wdata data request, write enable, address, write data
//   d_ack/d_rdata            data completion pulse and read data
//   mem_a/mem_we/mem_wd      shared memory address, write strobe, write data
//   mem_out                  shared memory read data
//   dbg_state                current FSM state (IDLE=0, BUSY=1, RESP=2)
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_out,
    output logic [1:0]        dbg_state
);

    localparam logic [CNT_W-1:0] LAT_LOAD = lat_load(MEM_LAT);

    state_t            r_state;
    state_t            w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    owner_t            r_last;
    owner_t            r_owner;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;

    logic [1:0]        w_grant;
    logic              w_any_grant;
    logic              w_last_busy;

    rr_arb2 u_rr_arb2 (
        .i_req_if (if_req),
        .i_req_d  (d_req),
        .i_last   (r_last),
        .o_grant  (w_grant)
    );

    // Only IDLE looks at the grant, so requests are ignored in BUSY/RESP.
    assign w_any_grant = (r_state == ST_IDLE) && (w_grant != 2'b00);
    assign w_last_busy = (r_state == ST_BUSY) && (r_cnt == '0);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and state-decoded outputs. mem_we and the acks are decoded
    // from the state register, so asserting reset drops them immediately.
    always_comb begin
        w_next_state = r_state;
        mem_we       = 1'b0;
        if_ack       = 1'b0;
        d_ack        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_grant) begin
                    w_next_state = ST_BUSY;
                end
            end
            ST_BUSY: begin
                mem_we = w_last_busy && r_we;
                if (w_last_busy) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                if_ack       = (r_owner == OWN_IF);
                d_ack        = (r_owner == OWN_D);
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Access registers: latched on the grant edge, read data captured on the
    // final BUSY edge. The instruction port never writes, so a fetch keeps
    // the previous write data on mem_wd.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_last  <= OWN_IF;
            r_owner <= OWN_IF;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_any_grant) begin
                r_cnt <= LAT_LOAD;
                if (w_grant[1]) begin
                    r_owner <= OWN_D;
                    r_addr  <= d_addr;
                    r_we    <= d_we;
                    r_wdata <= d_wdata;
                end else begin
                    r_owner <= OWN_IF;
                    r_addr  <= if_addr;
                    r_we    <= 1'b0;
                end
            end else if (r_state == ST_BUSY) begin
                if (w_last_busy) begin
                    r_rdata <= mem_out;
                    r_last  <= r_owner;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

    assign mem_a     = r_addr;
    assign mem_wd    = r_wdata;
    assign if_rdata  = r_rdata;
    assign d_rdata   = r_rdata;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // index 0: MEM_LAT=1 instance, index 1: MEM_LAT=4 instance
  logic          if_req   [2];
  logic [AW-1:0] if_addr  [2];
  logic          if_ack   [2];
  logic [DW-1:0] if_rdata [2];
  logic          d_req    [2];
  logic          d_we     [2];
  logic [AW-1:0] d_addr   [2];
  logic [DW-1:0] d_wdata  [2];
  logic          d_ack    [2];
  logic [DW-1:0] d_rdata  [2];
  logic [AW-1:0] mem_a    [2];
  logic          mem_we   [2];
  logic [DW-1:0] mem_wd   [2];
  logic [DW-1:0] mem_out  [2];
  logic [1:0]    dbg_state[2];

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_ack(if_ack[0]), .if_rdata(if_rdata[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_ack(d_ack[0]), .d_rdata(d_rdata[0]),
    .mem_a(mem_a[0]), .mem_we(mem_we[0]), .mem_wd(mem_wd[0]), .mem_out(mem_out[0]),
    .dbg_state(dbg_state[0])
  );

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_ack(if_ack[1]), .if_rdata(if_rdata[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_ack(d_ack[1]), .d_rdata(d_rdata[1]),
    .mem_a(mem_a[1]), .mem_we(mem_we[1]), .mem_wd(mem_wd[1]), .mem_out(mem_out[1]),
    .dbg_state(dbg_state[1])
  );

  // ---------------- memory models (word addressed, async read) ----------------
  logic [DW-1:0] mem [2][64];
  assign mem_out[0] = mem[0][mem_a[0][7:2]];
  assign mem_out[1] = mem[1][mem_a[1][7:2]];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (mem_we[k]) mem[k][mem_a[k][7:2]] <= mem_wd[k];
    end
  end

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // ---------------- scoreboard / monitor ----------------
  // entry = {instance, port (1=data), rdata}
  logic [DW+1:0] exp_q[$];
  int            we_cnt  [2] = '{0, 0};
  logic [AW-1:0] we_addr [2];
  logic [DW-1:0] we_data [2];

  always @(negedge clk) begin
    logic [DW+1:0] e;
    for (int k = 0; k < 2; k++) begin
      if (mem_we[k]) begin
        we_cnt[k]++;
        we_addr[k] = mem_a[k];
        we_data[k] = mem_wd[k];
      end
      if (if_ack[k] || d_ack[k]) begin
        if (if_ack[k] && d_ack[k]) begin
          n_checks++;
          $display("FAIL both_acks: inst %0d raised if_ack and d_ack together", k);
        end else if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_ack: inst %0d if_ack=%0b d_ack=%0b with nothing expected",
                   k, if_ack[k], d_ack[k]);
        end else begin
          e = exp_q.pop_front();
          chk("ack_instance", 64'(k), 64'(e[DW+1]));
          chk("ack_port", 64'(d_ack[k]), 64'(e[DW]));
          chk("ack_rdata", 64'(d_ack[k] ? d_rdata[k] : if_rdata[k]), 64'(e[DW-1:0]));
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Single access; expected ack cycle = request cycle + 1 + lat.
  task automatic access(input int k, input bit port_d, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd, input int lat,
                        input string nm);
    int t0;
    bit got;
    @(posedge clk); #1;
    exp_q.push_back({1'(k), port_d, exp_rd});
    t0 = cyc;
    if (port_d) begin
      d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wd;
    end else begin
      if_req[k] = 1'b1; if_addr[k] = addr;
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (port_d ? d_ack[k] : if_ack[k]) got = 1'b1;
    end
    chk({nm, "_ack_seen"}, 64'(got), 64'd1);
    if (got) chk({nm, "_latency"}, 64'(cyc - t0), 64'(1 + lat));
    @(posedge clk); #1;
    d_req[k]  = 1'b0;
    if_req[k] = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int t0, w0, last_ack, n_acks;
    bit got;

    for (int k = 0; k < 2; k++) begin
      if_req[k] = 1'b0; if_addr[k] = '0;
      d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
      for (int i = 0; i < 64; i++) mem[k][i] = (k == 0) ? (32'hA5A5_0000 | i) : (32'h5A5A_0000 | i);
    end
    mem[0][4] = 32'hDEADBEEF;

    // reset with both requests already high on the MEM_LAT=1 instance
    rst = 1'b0;
    if_req[0] = 1'b1; if_addr[0] = 16'h0010;
    d_req[0]  = 1'b1; d_we[0] = 1'b0; d_addr[0] = 16'h0024;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_state", 64'(dbg_state[k]), 64'd0);
      chk("rst_if_ack", 64'(if_ack[k]), 64'd0);
      chk("rst_d_ack", 64'(d_ack[k]), 64'd0);
      chk("rst_mem_we", 64'(mem_we[k]), 64'd0);
      chk("rst_mem_a", 64'(mem_a[k]), 64'd0);
      chk("rst_mem_wd", 64'(mem_wd[k]), 64'd0);
      chk("rst_rdata", 64'(if_rdata[k]), 64'd0);
    end

    // continuous tie: D, IF, D, IF with one ack every 3 cycles
    exp_q.push_back({1'b0, 1'b1, 32'hA5A5_0009});
    exp_q.push_back({1'b0, 1'b0, 32'hDEADBEEF});
    exp_q.push_back({1'b0, 1'b1, 32'hA5A5_0009});
    exp_q.push_back({1'b0, 1'b0, 32'hDEADBEEF});
    rst = 1'b1;
    t0 = cyc;
    last_ack = t0 - 1;
    n_acks = 0;
    for (int n = 0; n < 4; n++) begin
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge clk);
        if (if_ack[0] || d_ack[0]) got = 1'b1;
      end
      chk("tie_ack_seen", 64'(got), 64'd1);
      if (got) begin
        chk("tie_ack_spacing", 64'(cyc - last_ack), (n == 0) ? 64'd3 : 64'd3);
        last_ack = cyc;
        n_acks++;
      end
    end
    chk("tie_ack_count", 64'(n_acks), 64'd4);
    @(posedge clk); #1;
    if_req[0] = 1'b0; d_req[0] = 1'b0;
    repeat (2) @(posedge clk);

    // lone fetch after IF was served last; no write strobe
    w0 = we_cnt[0];
    access(0, 1'b0, 1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, 1, "if_read");
    chk("if_read_no_we", 64'(we_cnt[0] - w0), 64'd0);

    // write returns pre-write word, one strobe, then read back
    w0 = we_cnt[0];
    access(0, 1'b1, 1'b1, 16'h0020, 32'h12345678, 32'hA5A5_0008, 1, "d_write");
    chk("write_we_pulses", 64'(we_cnt[0] - w0), 64'd1);
    chk("write_we_addr", 64'(we_addr[0]), 64'h0020);
    chk("write_we_data", 64'(we_data[0]), 64'h12345678);
    access(0, 1'b1, 1'b0, 16'h0020, 32'h0, 32'h12345678, 1, "d_readback");

    // MEM_LAT=4: address held through BUSY despite d_addr changing
    @(posedge clk); #1;
    exp_q.push_back({1'b1, 1'b1, 32'h5A5A_000C});
    t0 = cyc;
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 16'h0030;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("lat4_busy_state", 64'(dbg_state[1]), 64'd1);
      chk("lat4_mem_a", 64'(mem_a[1]), 64'h0030);
      chk("lat4_no_ack", 64'(d_ack[1]), 64'd0);
      if (i == 0) d_addr[1] = 16'h0034;
    end
    got = 1'b0;
    for (int i = 0; i < 5 && !got; i++) begin
      @(negedge clk);
      if (d_ack[1]) got = 1'b1;
    end
    chk("lat4_ack_seen", 64'(got), 64'd1);
    if (got) chk("lat4_latency", 64'(cyc - t0), 64'd5);
    @(posedge clk); #1;
    d_req[1] = 1'b0;
    access(1, 1'b0, 1'b0, 16'h0034, 32'h0, 32'h5A5A_000D, 4, "lat4_if_read");
    w0 = we_cnt[1];
    access(1, 1'b1, 1'b1, 16'h0038, 32'hBEEF0004, 32'h5A5A_000E, 4, "lat4_write");
    chk("lat4_we_pulses", 64'(we_cnt[1] - w0), 64'd1);
    chk("lat4_we_addr", 64'(we_addr[1]), 64'h0038);

    // reset during the final BUSY cycle of a write
    @(posedge clk); #1;
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 16'h0040; d_wdata[0] = 32'h0BADF00D;
    @(negedge clk);
    @(negedge clk); #1;
    chk("abort_we_before", 64'(mem_we[0]), 64'd1);
    rst = 1'b0;
    #1;
    chk("abort_we_dropped", 64'(mem_we[0]), 64'd0);
    chk("abort_state_idle", 64'(dbg_state[0]), 64'd0);
    chk("abort_no_d_ack", 64'(d_ack[0]), 64'd0);
    d_req[0] = 1'b0; d_we[0] = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    access(0, 1'b1, 1'b0, 16'h0040, 32'h0, 32'hA5A5_0010, 1, "post_rst_read");

    repeat (5) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 16, memory byte-address width; DATA_W, default 32, data width; MEM_LAT, default 1, memory cycles per access (legal 1..7).
REQ-002 Ports SHALL be, clock and reset first:
clk  in  1  single clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
if_req  in  1  instruction-fetch read request, held until if_ack
if_addr  in  ADDR_W  fetch byte address
if_ack  out  1  fetch complete, one-cycle pulse
if_rdata  out  DATA_W  fetch data, valid while if_ack=1
d_req  in  1  data-port request, held until d_ack
d_we  in  1  data-port write enable (1=write, 0=read)
d_addr  in  ADDR_W  data byte address
d_wdata  in  DATA_W  data write value
d_ack  out  1  data access complete, one-cycle pulse
d_rdata  out  DATA_W  data read value, valid while d_ack=1
mem_a  out  ADDR_W  shared memory address
mem_we  out  1  shared memory write enable
mem_wd  out  DATA_W  shared memory write data
mem_out  in  DATA_W  shared memory read data

Function
REQ-003 The block SHALL use a three-state FSM: IDLE, BUSY, RESP.
REQ-004 IDLE: no request -> stay; any request -> latch owner, address, we, wdata into internal registers and go BUSY on the same edge.
REQ-005 With both requests high in IDLE, the block SHALL grant the port not granted last (round-robin); a lone request SHALL be granted regardless of history.
REQ-006 BUSY SHALL last exactly MEM_LAT cycles, counted by a 3-bit counter loaded with MEM_LAT-1 on entry and decremented each cycle.
REQ-007 Throughout BUSY, mem_a and mem_wd SHALL be driven from the latched registers and held stable.
REQ-008 mem_we SHALL be 1 only in the final BUSY cycle of a write, and 0 otherwise.
REQ-009 On the final BUSY edge, the block SHALL register mem_out into a read-data register, update last-grant to the owner, and go RESP.
REQ-010 RESP SHALL last one cycle: the owner's ack=1 and the owner's rdata equal the registered value; the other port's ack=0; then go IDLE.
REQ-011 For writes, rdata in the ack cycle SHALL be the pre-write memory word; requesters ignore it.
REQ-012 Latency from the req-sampled edge to the ack cycle SHALL be MEM_LAT+1 cycles; minimum request spacing per grant is MEM_LAT+2 cycles.
REQ-013 A requester holding req high through its ack cycle SHALL be treated as a new request in the following IDLE cycle.
REQ-014 Request inputs SHALL be sampled only in IDLE; changes to addr, wdata or we during BUSY or RESP SHALL not affect the access in flight.
REQ-015 Outside BUSY, mem_we SHALL be 0; mem_a and mem_wd SHALL hold their last values.
REQ-016 if_rdata and d_rdata SHALL both be driven from the single read-data register; they are meaningful only with their ack.
REQ-017 Addresses SHALL pass through unmodified; word alignment is the memory's concern.

Reset
REQ-018 rst=0 SHALL asynchronously force: FSM=IDLE, counter=0, last-grant=instruction port (first tie goes to data), latched address, wdata and read-data registers=0, mem_we=0, if_ack=0, d_ack=0.
REQ-019 Reset asserted during BUSY SHALL abort the access with no mem_we pulse after assertion and no ack; a write already committed is not undone.
REQ-020 After reset release, the first arbitration SHALL occur on the first rising edge with rst=1.

Structure
REQ-021 A shared package SHALL hold the FSM state encoding (2 bits: IDLE=0, BUSY=1, RESP=2) and the owner encoding (OWN_IF=0, OWN_D=1).
REQ-022 The round-robin grant SHALL be a sub-module, rr_arb2: inputs are two requests and last-grant; output is a one-hot grant; it is purely combinational.

Verification
REQ-023 Reset, then if_req=1, if_addr=0x0010 with mem[4]=0xDEADBEEF, MEM_LAT=1 -> if_ack high exactly 2 cycles later, if_rdata=0xDEADBEEF, d_ack=0, mem_we never 1.
REQ-024 d_req=1, d_we=1, d_addr=0x0020, d_wdata=0x12345678 -> mem_we pulses for one cycle with mem_a=0x0020; a following read of 0x0020 returns 0x12345678.
REQ-025 Both requests high continuously after reset -> grants alternate D, IF, D, IF, ... and each ack appears every 3 cycles at MEM_LAT=1.
REQ-026 MEM_LAT=4, single read -> mem_a stable for 4 cycles, ack 5 cycles after the request; changing d_addr mid-BUSY has no effect.
REQ-027 rst pulled low in the final BUSY cycle of a write -> mem_we drops immediately, no ack, FSM=IDLE; normal operation resumes after release.
